// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable full/empty levels and a standard or first-word-fall-through read port.
// Count and all status flags are registered from next-state values, so they always change on the same edge.
module sync_fifo_prog #(
   parameter int DWIDTH            = 64,
   parameter int DEPTH             = 16,
   parameter int FWFT              = 0,
   parameter int PROG_FULL_THRESH  = DEPTH - 2,
   parameter int PROG_EMPTY_THRESH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [DWIDTH-1:0]        wr_data,
   output logic                     wr_full,
   input  logic                     rd_en,
   output logic [DWIDTH-1:0]        rd_data,
   output logic                     rd_empty,
   output logic                     rd_valid,
   output logic [$clog2(DEPTH):0]   fifo_cnt,
   output logic                     prog_full,
   output logic                     prog_empty,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] PF_LVL = CW'(PROG_FULL_THRESH);
   localparam logic [CW-1:0] PE_LVL = CW'(PROG_EMPTY_THRESH);

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]     wr_ptr;
   logic [CW-1:0]     rd_ptr;
   logic [CW-1:0]     wr_ptr_nxt;
   logic [CW-1:0]     rd_ptr_nxt;
   logic [CW-1:0]     cnt_nxt;
   logic              wr_acc;
   logic              rd_acc;

   // Acceptance looks only at this cycle's flags: a pop never frees room for a same-cycle push.
   assign wr_acc = wr_en & ~wr_full;
   assign rd_acc = rd_en & ~rd_empty;

   always_comb begin
      wr_ptr_nxt = wr_ptr + (wr_acc ? CW'(1) : CW'(0));
      rd_ptr_nxt = rd_ptr + (rd_acc ? CW'(1) : CW'(0));
      cnt_nxt    = fifo_cnt;
      if (wr_acc && !rd_acc) begin
         cnt_nxt = fifo_cnt + CW'(1);
      end else if (!wr_acc && rd_acc) begin
         cnt_nxt = fifo_cnt - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_cnt   <= '0;
         rd_empty   <= 1'b1;
         wr_full    <= 1'b0;
         prog_full  <= 1'b0;
         prog_empty <= 1'b1;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         wr_ptr     <= wr_ptr_nxt;
         rd_ptr     <= rd_ptr_nxt;
         fifo_cnt   <= cnt_nxt;
         // Pointer MSBs differ only when the writer has lapped the reader.
         rd_empty   <= (wr_ptr_nxt == rd_ptr_nxt);
         wr_full    <= (wr_ptr_nxt == {~rd_ptr_nxt[AW], rd_ptr_nxt[AW-1:0]});
         prog_full  <= (cnt_nxt >= PF_LVL);
         prog_empty <= (cnt_nxt <= PE_LVL);
         overflow   <= wr_en & wr_full;
         underflow  <= rd_en & rd_empty;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign rd_data  = rd_empty ? '0 : mem[rd_ptr[AW-1:0]];
         assign rd_valid = ~rd_empty;
      end else begin : g_std
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rd_data  <= '0;
               rd_valid <= 1'b0;
            end else begin
               rd_valid <= rd_acc;
               if (rd_acc) begin
                  rd_data <= mem[rd_ptr[AW-1:0]];
               end
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Drives a standard-read and an FWFT instance with identical traffic and checks both against a queue model.
module tb_sync_fifo_prog;
   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int PFT   = DEPTH - 2;
   localparam int PET   = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic          rd_en;
   logic [DW-1:0] wr_data;

   logic          wr_full0, rd_empty0, rd_valid0, prog_full0, prog_empty0, overflow0, underflow0;
   logic [DW-1:0] rd_data0;
   logic [4:0]    fifo_cnt0;
   logic          wr_full1, rd_empty1, rd_valid1, prog_full1, prog_empty1, overflow1, underflow1;
   logic [DW-1:0] rd_data1;
   logic [4:0]    fifo_cnt1;

   sync_fifo_prog #(.DWIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full0),
      .rd_en(rd_en), .rd_data(rd_data0), .rd_empty(rd_empty0), .rd_valid(rd_valid0),
      .fifo_cnt(fifo_cnt0), .prog_full(prog_full0), .prog_empty(prog_empty0),
      .overflow(overflow0), .underflow(underflow0)
   );

   sync_fifo_prog #(.DWIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full1),
      .rd_en(rd_en), .rd_data(rd_data1), .rd_empty(rd_empty1), .rd_valid(rd_valid1),
      .fifo_cnt(fifo_cnt1), .prog_full(prog_full1), .prog_empty(prog_empty1),
      .overflow(overflow1), .underflow(underflow1)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mdl[$];   // reference contents, head at index 0
   logic [DW-1:0] sb[$];    // words the standard port still owes
   logic          exp_ovf, exp_unf, exp_rv;
   logic [DW-1:0] last_rd0;
   int            errors = 0;
   int            checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_flags(input string tag, input logic [4:0] cnt, input logic full, input logic empty,
                            input logic pf, input logic pe, input logic ovf, input logic unf);
      int n;
      n = mdl.size();
      chk({tag, " fifo_cnt"},   cnt,   n);
      chk({tag, " wr_full"},    full,  n == DEPTH);
      chk({tag, " rd_empty"},   empty, n == 0);
      chk({tag, " prog_full"},  pf,    n >= PFT);
      chk({tag, " prog_empty"}, pe,    n <= PET);
      chk({tag, " overflow"},   ovf,   exp_ovf);
      chk({tag, " underflow"},  unf,   exp_unf);
   endtask

   task automatic chk_reset();
      chk("rst std fifo_cnt", fifo_cnt0, 0);
      chk("rst std rd_empty", rd_empty0, 1);
      chk("rst std wr_full", wr_full0, 0);
      chk("rst std prog_empty", prog_empty0, 1);
      chk("rst std prog_full", prog_full0, 0);
      chk("rst std rd_valid", rd_valid0, 0);
      chk("rst std overflow", overflow0, 0);
      chk("rst std underflow", underflow0, 0);
      chk("rst std rd_data", rd_data0, 0);
      chk("rst fwft fifo_cnt", fifo_cnt1, 0);
      chk("rst fwft rd_empty", rd_empty1, 1);
      chk("rst fwft rd_valid", rd_valid1, 0);
      chk("rst fwft rd_data", rd_data1, 0);
   endtask

   // One clock of stimulus; the model advances on the same edge the DUT does.
   task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
      int n;
      wr_en   = w;
      rd_en   = r;
      wr_data = d;
      @(posedge clk);
      n = mdl.size();
      exp_ovf = w && (n == DEPTH);
      exp_unf = r && (n == 0);
      exp_rv  = r && (n > 0);
      if (r && n > 0) sb.push_back(mdl.pop_front());
      if (w && n < DEPTH) mdl.push_back(d);
      #1;
   endtask

   task automatic async_reset();
      wr_en = 1'b0;
      rd_en = 1'b0;
      #2;
      rst = 1'b1;
      mdl.delete();
      sb.delete();
      exp_ovf  = 1'b0;
      exp_unf  = 1'b0;
      exp_rv   = 1'b0;
      last_rd0 = '0;
      #1;
      chk_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Monitor: samples on the falling edge, away from the DUT's active edge.
   always @(negedge clk) begin
      chk_flags("std", fifo_cnt0, wr_full0, rd_empty0, prog_full0, prog_empty0, overflow0, underflow0);
      chk_flags("fwft", fifo_cnt1, wr_full1, rd_empty1, prog_full1, prog_empty1, overflow1, underflow1);
      chk("std rd_valid", rd_valid0, exp_rv);
      if (rd_valid0) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL std scoreboard: rd_valid with no word owed, rd_data %0h", rd_data0);
         end else begin
            last_rd0 = sb.pop_front();
            chk("std rd_data", rd_data0, last_rd0);
         end
      end else begin
         chk("std rd_data hold", rd_data0, last_rd0);
      end
      chk("fwft rd_valid", rd_valid1, mdl.size() > 0);
      if (mdl.size() > 0) chk("fwft rd_data", rd_data1, mdl[0]);
   end

   initial begin
      rst      = 1'b1;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      wr_data  = '0;
      exp_ovf  = 1'b0;
      exp_unf  = 1'b0;
      exp_rv   = 1'b0;
      last_rd0 = '0;
      #1;
      chk_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Fill with 0..15, one rejected write, then drain in order.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(i));
      step(1'b1, 1'b0, 32'hDEAD_BEEF);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0);
      step(1'b0, 1'b0, '0);

      // Read from empty.
      step(1'b0, 1'b1, '0);
      step(1'b0, 1'b0, '0);

      // Single word into empty FIFO, left idle, then popped.
      step(1'b1, 1'b0, 32'hA5);
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b1, '0);
      step(1'b0, 1'b0, '0);

      // Hold at eight words with simultaneous traffic long enough to wrap twice.
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, $urandom);
      for (int i = 0; i < 40; i++) step(1'b1, 1'b1, $urandom);

      // Full with read and write together: only the read goes through.
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, $urandom);
      step(1'b1, 1'b1, 32'hBAD0_0001);
      step(1'b0, 1'b0, '0);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0);

      // Reset with five words stored, then new traffic only.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h5000 + DW'(i));
      async_reset();
      step(1'b1, 1'b0, 32'h1234);
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b1, '0);
      step(1'b0, 1'b0, '0);

      // Random traffic, first write-heavy then read-heavy.
      for (int i = 0; i < 250; i++)
         step($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 40, $urandom);
      for (int i = 0; i < 250; i++)
         step($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 65, $urandom);

      for (int i = 0; i <= DEPTH; i++) step(1'b0, 1'b1, '0);
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      chk("scoreboard drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sync_fifo_prog.md
SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

Interface
REQ-001 SHALL have parameter DWIDTH, default 64, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, entry count; power of two, >=4.
REQ-003 SHALL have parameter FWFT, default 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through.
REQ-004 SHALL have parameter PROG_FULL_THRESH, default DEPTH-2, prog_full assert level (1..DEPTH).
REQ-005 SHALL have parameter PROG_EMPTY_THRESH, default 2, prog_empty assert level (0..DEPTH-1).
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port wr_en  input  1  write request.
REQ-009 SHALL have port wr_data  input  DWIDTH  write data.
REQ-010 SHALL have port wr_full  output  1  FIFO holds DEPTH words.
REQ-011 SHALL have port rd_en  input  1  read request (FWFT: pop head).
REQ-012 SHALL have port rd_data  output  DWIDTH  read data.
REQ-013 SHALL have port rd_empty  output  1  FIFO holds 0 words.
REQ-014 SHALL have port rd_valid  output  1  rd_data carries a newly read word.
REQ-015 SHALL have port fifo_cnt  output  $clog2(DEPTH)+1  words stored.
REQ-016 SHALL have port prog_full  output  1  fifo_cnt >= PROG_FULL_THRESH.
REQ-017 SHALL have port prog_empty  output  1  fifo_cnt <= PROG_EMPTY_THRESH.
REQ-018 SHALL have port overflow  output  1  one-cycle pulse: write rejected.
REQ-019 SHALL have port underflow  output  1  one-cycle pulse: read rejected.

Function
REQ-020 SHALL accept a write iff wr_en=1 and wr_full=1'b0 in that cycle; accepted word stored at wr pointer, pointer +1.
REQ-021 SHALL accept a read iff rd_en=1 and rd_empty=0 in that cycle; rd pointer +1.
REQ-022 SHALL keep wr/rd pointers $clog2(DEPTH)+1 bits wide, address = low bits, wrap DEPTH-1 -> 0 with MSB toggle.
REQ-023 SHALL update fifo_cnt registered: +1 write only, -1 read only, unchanged both or neither; never exceeds DEPTH or goes below 0.
REQ-024 SHALL derive wr_full, rd_empty, prog_full, prog_empty as registers consistent with fifo_cnt in the same cycle (all change on the same edge as fifo_cnt).
REQ-025 SHALL evaluate flags at the current cycle only: read on a full FIFO does not enable a same-cycle write; write on an empty FIFO does not enable a same-cycle read.
REQ-026 SHALL, when FWFT=0, register mem[rd_addr] into rd_data on the edge after an accepted read (latency 1) and pulse rd_valid high for that cycle; rd_data holds value otherwise.
REQ-027 SHALL, when FWFT=1, present head word on rd_data whenever rd_empty=0, rd_valid = ~rd_empty; a word written into an empty FIFO at edge N is visible after edge N (rd_empty=0 from N).
REQ-028 SHALL, in FWFT=1, advance rd_data to the next word on the edge consuming an accepted read.
REQ-029 SHALL pulse overflow for exactly one cycle after an edge where wr_en=1 and wr_full=1; FIFO contents unchanged.
REQ-030 SHALL pulse underflow for exactly one cycle after an edge where rd_en=1 and rd_empty=1; pointers unchanged.
REQ-031 SHALL preserve data order and integrity across any number of pointer wraps.

Reset
REQ-032 SHALL, on rst=1 (async, no clock needed), force: pointers 0, fifo_cnt 0, rd_empty 1, wr_full 0, prog_empty 1, prog_full 0, rd_valid 0, overflow 0, underflow 0, rd_data 0.
REQ-033 SHALL not reset storage array; contents after reset are don't-care and never visible.
REQ-034 SHALL, on rst mid-operation, discard all stored words; first post-reset write behaves as into an empty FIFO.

Verification
REQ-035 SHALL cover: DEPTH=16, FWFT=0, write 0..15 -> wr_full=1 after 16th edge, fifo_cnt=16, prog_full=1 from cnt=14; 17th write -> overflow pulse, read-back 0..15 with rd_valid, 1-cycle latency.
REQ-036 SHALL cover: empty FIFO, rd_en=1 -> underflow one cycle, fifo_cnt stays 0, rd_valid 0.
REQ-037 SHALL cover: FWFT=1, single write 0xA5 -> rd_empty=0 and rd_data=0xA5 next cycle without rd_en; rd_en pop -> rd_empty=1.
REQ-038 SHALL cover: cnt=8, simultaneous wr_en/rd_en for 40 cycles -> fifo_cnt stays 8, pointers wrap twice, data order preserved.
REQ-039 SHALL cover: full FIFO with wr_en=rd_en=1 -> read accepted, write rejected (overflow pulse), fifo_cnt=15.
REQ-040 SHALL cover: rst asserted asynchronously between edges with cnt=5 -> all outputs at REQ-032 values immediately; post-reset write/read returns new data only.
